// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Double-buffered value commits at frame boundaries; PWM brightness, blink, LZ suppress.
module seg_scan_ctrl #(
    parameter int DIGITS         = 8,
    parameter int CLK_DIV        = 16,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_suppress,
    input  logic [3:0]            bright,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     sel_out,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [7:0] SEG_OFF =
        (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF =
        (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic                  blink_q, blink_d;
    logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [4*DIGITS-1:0]   act_data_q, act_data_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic                  pending_q, pending_d;
    logic                  fdone_q, fdone_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     sel_q, sel_d;

    logic                  last_slot;
    logic                  frame_end;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic [DIGITS-1:0]     lz_zero;
    logic                  zrun;
    logic                  dark;
    logic [7:0]            seg_lit;
    logic [31:0]           on_len;
    logic [31:0]           on_max;
    logic [31:0]           pcnt_w;
    logic                  sel_on;
    logic [DIGITS-1:0]     onehot;

    // Hex digit to segment pattern, active-low form, dp bit unlit.
    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'h0: r = 8'hC0;
            4'h1: r = 8'hF9;
            4'h2: r = 8'hA4;
            4'h3: r = 8'hB0;
            4'h4: r = 8'h99;
            4'h5: r = 8'h92;
            4'h6: r = 8'h82;
            4'h7: r = 8'hF8;
            4'h8: r = 8'h80;
            4'h9: r = 8'h90;
            4'hA: r = 8'h88;
            4'hB: r = 8'h83;
            4'hC: r = 8'hC6;
            4'hD: r = 8'hA1;
            4'hE: r = 8'h86;
            default: r = 8'h8E;
        endcase
        return r;
    endfunction

    assign last_slot = (pcnt_q == PW'(CLK_DIV - 1));
    assign frame_end = last_slot && (idx_q == IW'(DIGITS - 1));
    assign cur_nib   = act_data_q[{idx_q, 2'b00} +: 4];
    assign cur_dp    = act_dp_q[idx_q];

    // lz_zero[i]: every digit from i upward is a plain zero with no dp.
    always_comb begin
        zrun    = 1'b1;
        lz_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zrun = zrun && (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
            lz_zero[i] = zrun;
        end
    end

    // Decide what the current slot drives: darkness, pattern and PWM window.
    always_comb begin
        dark = blank_in[idx_q]
            || (blink_mask[idx_q] && blink_q)
            || (lz_suppress && (idx_q != '0) && lz_zero[idx_q]);
        seg_lit = enc(cur_nib) & {~cur_dp, 7'h7F};
        if (dark) begin
            seg_d = SEG_OFF;
        end else if (SEG_ACTIVE_LOW != 0) begin
            seg_d = seg_lit;
        end else begin
            seg_d = ~seg_lit;
        end
        on_len = ((32'(bright) + 32'd1) * 32'(CLK_DIV)) >> 4;
        on_max = (on_len > 32'(CLK_DIV - 1)) ? 32'(CLK_DIV - 1) : on_len;
        pcnt_w = 32'(pcnt_q);
        sel_on = !dark && (pcnt_w >= 32'd1) && (pcnt_w <= on_max);
        onehot = DIGITS'(1) << idx_q;
        if (!sel_on) begin
            sel_d = SEL_OFF;
        end else if (SEL_ACTIVE_LOW != 0) begin
            sel_d = ~onehot;
        end else begin
            sel_d = onehot;
        end
    end

    // Next-state for scan counters, blink phase and the two buffers.
    always_comb begin
        pcnt_d      = last_slot ? '0 : pcnt_q + PW'(1);
        idx_d       = idx_q;
        fcnt_d      = fcnt_q;
        blink_d     = blink_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        if (last_slot) begin
            idx_d = frame_end ? '0 : idx_q + IW'(1);
        end
        if (frame_end) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
            if (pending_q) begin
                act_data_d = pend_data_q;
                act_dp_d   = pend_dp_q;
            end
        end
        if (load) begin
            pend_data_d = data;
            pend_dp_d   = dp_in;
        end
        pending_d = load || (pending_q && !frame_end);
        fdone_d   = frame_end;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q      <= '0;
            idx_q       <= '0;
            fcnt_q      <= '0;
            blink_q     <= 1'b0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            pending_q   <= 1'b0;
            fdone_q     <= 1'b0;
            seg_q       <= SEG_OFF;
            sel_q       <= SEL_OFF;
        end else begin
            pcnt_q      <= pcnt_d;
            idx_q       <= idx_d;
            fcnt_q      <= fcnt_d;
            blink_q     <= blink_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            pending_q   <= pending_d;
            fdone_q     <= fdone_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
        end
    end

    assign seg_out    = seg_q;
    assign sel_out    = sel_q;
    assign pending    = pending_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios then random stimulus,
// every cycle compared against a timeline-based reference model.
module tb_seg_scan_ctrl;

    localparam int ND = 8;
    localparam int CD = 16;
    localparam int BF = 2;
    localparam int FL = ND * CD;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic [7:0]  blink_mask;
    logic        lz_suppress;
    logic [3:0]  bright;
    logic [7:0]  seg_out;
    logic [7:0]  sel_out;
    logic        pending;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS(ND),
        .CLK_DIV(CD),
        .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1),
        .SEL_ACTIVE_LOW(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .data(data),
        .dp_in(dp_in),
        .blank_in(blank_in),
        .blink_mask(blink_mask),
        .lz_suppress(lz_suppress),
        .bright(bright),
        .seg_out(seg_out),
        .sel_out(sel_out),
        .pending(pending),
        .frame_done(frame_done)
    );

    typedef struct {
        int          c;
        logic [31:0] d;
        logic [7:0]  dp;
    } ld_t;

    ld_t lq[$];
    int  t;
    int  total;
    int  bad;

    logic [7:0] enc_tbl [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    // A load in cycle c becomes the shown value from frame (c+1)/FL + 1.
    function automatic int act_frame(input int c);
        return (c + 1) / FL + 1;
    endfunction

    // Expected outputs in cycle t follow from cycle t-1 position and inputs,
    // which are still on the pins when this runs.
    task automatic model_check();
        logic [31:0] ad;
        logic [7:0]  adp;
        logic [7:0]  es;
        logic [7:0]  esel;
        logic [3:0]  nib;
        bit          bl, dark, zr, pe, fd;
        int          s, pc, ix, f, onm;
        if (t == 0) begin
            es   = 8'hFF;
            esel = 8'h00;
        end else begin
            s  = t - 1;
            pc = s % CD;
            ix = (s / CD) % ND;
            f  = s / FL;
            bl = ((f / BF) % 2) == 1;
            ad  = 32'h0;
            adp = 8'h0;
            foreach (lq[k]) begin
                if (act_frame(lq[k].c) <= f) begin
                    ad  = lq[k].d;
                    adp = lq[k].dp;
                end
            end
            zr = 1'b1;
            for (int j = ix; j < ND; j++) begin
                if (ad[4*j +: 4] != 4'h0 || adp[j]) zr = 1'b0;
            end
            dark = blank_in[ix] || (blink_mask[ix] && bl)
                || (lz_suppress && ix != 0 && zr);
            nib = ad[4*ix +: 4];
            es = dark ? 8'hFF
                : (enc_tbl[nib] & (adp[ix] ? 8'h7F : 8'hFF));
            onm = ((int'(bright) + 1) * CD) / 16;
            if (onm > CD - 1) onm = CD - 1;
            esel = (!dark && pc >= 1 && pc <= onm) ? (8'd1 << ix) : 8'h00;
        end
        pe = 1'b0;
        foreach (lq[k]) begin
            if (lq[k].c < t && act_frame(lq[k].c) > t / FL) pe = 1'b1;
        end
        fd = (t > 0) && (t % FL == 0);
        chk("seg", 32'(seg_out), 32'(es));
        chk("sel", 32'(sel_out), 32'(esel));
        chk("pend", 32'(pending), 32'(pe));
        chk("fdone", 32'(frame_done), 32'(fd));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rst) begin
                t = 0;
                lq.delete();
            end else begin
                t++;
            end
            model_check();
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp);
        load  = 1'b1;
        data  = d;
        dp_in = dp;
        lq.push_back('{t, d, dp});
        step(1);
        load = 1'b0;
    endtask

    // Advance so the current cycle sits at digit ix, slot cycle pc.
    task automatic go_to(input int ix, input int pc);
        int n;
        n = ((ix * CD + pc) - (t % FL) + FL) % FL;
        if (n > 0) step(n);
    endtask

    initial begin
        logic [31:0] rd;
        total       = 0;
        bad         = 0;
        t           = 0;
        rst         = 1'b1;
        load        = 1'b0;
        data        = 32'h0;
        dp_in       = 8'h0;
        blank_in    = 8'h0;
        blink_mask  = 8'h0;
        lz_suppress = 1'b0;
        bright      = 4'hF;
        step(2);
        rst = 1'b0;

        do_load(32'h1234_5678, 8'h00);
        step(3 * FL);

        go_to(3, 5);
        do_load(32'h0000_000A, 8'h00);
        step(FL / 2);
        do_load(32'h0000_0111, 8'h00);
        do_load(32'h0000_0022, 8'h00);
        step(2 * FL);

        lz_suppress = 1'b1;
        do_load(32'h0000_00A0, 8'h00);
        step(2 * FL);
        do_load(32'h0000_00A0, 8'h08);
        step(2 * FL);
        lz_suppress = 1'b0;

        bright = 4'd0;
        step(FL);
        bright = 4'd7;
        step(FL);
        bright = 4'd15;
        step(FL);

        blink_mask = 8'h08;
        step(6 * FL);
        blink_mask = 8'h00;

        go_to(7, 15);
        do_load(32'h0000_BEEF, 8'h01);
        step(2 * FL);

        go_to(5, 7);
        do_load(32'h0000_0055, 8'h00);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2 * FL);

        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                blank_in    = 8'($urandom & $urandom & $urandom);
                blink_mask  = 8'($urandom & $urandom);
                lz_suppress = 1'($urandom);
                bright      = 4'($urandom);
            end
            if ($urandom_range(0, 3999) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                rd = $urandom;
                rd = rd >> (4 * $urandom_range(0, 8));
                do_load(rd,
                        ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
            end else begin
                step(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
